// File: rtl/regfile_dump_ctrl.sv
// Debug dump sequencer: walks the register file debug port from address 0 to
// 2**W-1 and streams every word out MSB byte first over a valid/ready byte link.
module regfile_dump_ctrl #(
   parameter int B = 32,
   parameter int W = 5
) (
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic         i_start,
   output logic [W-1:0] o_debug_addr,
   input  logic [B-1:0] i_reg_data,
   output logic [7:0]   o_tx_data,
   output logic         o_tx_valid,
   input  logic         i_tx_ready,
   output logic         o_busy,
   output logic         o_done
);
   // state  | meaning
   // IDLE   | waiting for i_start, no output activity
   // LATCH  | capture register word at o_debug_addr into shift register
   // SEND   | present top byte, shift on each accepted byte
   // DONE   | one-cycle completion pulse, address cleared

   localparam int NBYTES = B / 8;
   localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [CW-1:0] LAST_BYTE = CW'(NBYTES - 1);
   localparam logic [W-1:0] LAST_ADDR = {W{1'b1}};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LATCH = 2'd1,
      S_SEND  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t        r_state;
   logic [W-1:0]  r_addr;
   logic [B-1:0]  r_shift;
   logic [CW-1:0] r_byte_cnt;
   logic          r_tx_valid;
   logic          r_busy;
   logic          r_done;

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_state    <= S_IDLE;
         r_addr     <= '0;
         r_shift    <= '0;
         r_byte_cnt <= '0;
         r_tx_valid <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_addr  <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_LATCH;
               end
            end
            S_LATCH: begin
               r_shift    <= i_reg_data;
               r_byte_cnt <= '0;
               r_tx_valid <= 1'b1;
               r_state    <= S_SEND;
            end
            S_SEND: begin
               // Without ready every register holds, keeping the byte stable.
               if (i_tx_ready) begin
                  if (r_byte_cnt != LAST_BYTE) begin
                     r_shift    <= r_shift << 8;
                     r_byte_cnt <= r_byte_cnt + 1'b1;
                  end else begin
                     r_tx_valid <= 1'b0;
                     if (r_addr != LAST_ADDR) begin
                        r_addr  <= r_addr + 1'b1;
                        r_state <= S_LATCH;
                     end else begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                     end
                  end
               end
            end
            S_DONE: begin
               r_addr  <= '0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_debug_addr = r_addr;
   assign o_tx_data    = r_shift[B-1 -: 8];
   assign o_tx_valid   = r_tx_valid;
   assign o_busy       = r_busy;
   assign o_done       = r_done;

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Directed bench for regfile_dump_ctrl: default 32x32 instance plus a B=16, W=3
// instance, each fed by a behavioural register file.
module tb_regfile_dump_ctrl;

   logic clk;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, start, ready, sel;
   logic start_a, start_b;
   assign start_a = start & ~sel;
   assign start_b = start & sel;

   logic [4:0]  addr_a;
   logic [31:0] rdata_a;
   logic [7:0]  data_a;
   logic        valid_a, busy_a, done_a;
   logic [2:0]  addr_b;
   logic [15:0] rdata_b;
   logic [7:0]  data_b;
   logic        valid_b, busy_b, done_b;

   logic [31:0] regs_a [32];
   logic [15:0] regs_b [8];
   assign rdata_a = regs_a[addr_a];
   assign rdata_b = regs_b[addr_b];

   regfile_dump_ctrl #(.B(32), .W(5)) dut_a (
      .i_clk(clk), .i_reset(rst_n), .i_start(start_a),
      .o_debug_addr(addr_a), .i_reg_data(rdata_a),
      .o_tx_data(data_a), .o_tx_valid(valid_a), .i_tx_ready(ready),
      .o_busy(busy_a), .o_done(done_a)
   );

   regfile_dump_ctrl #(.B(16), .W(3)) dut_b (
      .i_clk(clk), .i_reset(rst_n), .i_start(start_b),
      .o_debug_addr(addr_b), .i_reg_data(rdata_b),
      .o_tx_data(data_b), .o_tx_valid(valid_b), .i_tx_ready(ready),
      .o_busy(busy_b), .o_done(done_b)
   );

   logic [7:0] obs_data;
   logic       obs_valid, obs_busy, obs_done;
   int         obs_addr;
   always_comb begin
      obs_data  = sel ? data_b  : data_a;
      obs_valid = sel ? valid_b : valid_a;
      obs_busy  = sel ? busy_b  : busy_a;
      obs_done  = sel ? done_b  : done_a;
      obs_addr  = sel ? int'(addr_b) : int'(addr_a);
   end

   int checks = 0;
   int errors = 0;
   logic [7:0] byte_q [$];
   int done_cyc [$];
   int done_cnt, stall_viol, restart_after_done, idle_after_done;

   function automatic logic [7:0] exp_a(input int n);
      logic [31:0] w;
      w = 32'hA500_0000 + 32'(n / 4);
      return 8'(w >> (24 - 8 * (n % 4)));
   endfunction

   function automatic logic [7:0] exp_b(input int n);
      logic [15:0] w;
      w = 16'h1200 + 16'(n / 2);
      return 8'(w >> (8 - 8 * (n % 2)));
   endfunction

   task automatic do_reset();
      rst_n = 1'b0; start = 1'b0; ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // Cycle c observes the state after c edges from the start edge (c=0 drives i_start).
   task automatic run(input int max_cyc, input int n_done, input int stop_bytes,
                      input bit rand_rdy, input bit hold_start, input int poke_addr);
      int extra;
      bit prev_stall, prev_done, rdy, st;
      logic [7:0] prev_data;
      byte_q.delete(); done_cyc.delete();
      done_cnt = 0; stall_viol = 0; restart_after_done = 0; idle_after_done = 0;
      extra = -1; prev_stall = 0; prev_done = 0; prev_data = '0;
      for (int c = 0; c < max_cyc; c++) begin
         if (prev_stall && (!obs_valid || obs_data !== prev_data)) stall_viol++;
         if (prev_done) begin
            if (obs_busy) restart_after_done++;
            else idle_after_done++;
         end
         if (obs_done) begin
            done_cnt++;
            done_cyc.push_back(c);
         end
         if (done_cnt >= n_done && extra < 0) extra = 4;
         rdy = rand_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
         st = (c == 0) || (hold_start && done_cnt < n_done) ||
              (poke_addr >= 0 && obs_busy && obs_addr == poke_addr);
         ready = rdy;
         start = st;
         if (obs_valid && rdy) byte_q.push_back(obs_data);
         prev_stall = obs_valid && !rdy;
         prev_data  = obs_data;
         prev_done  = obs_done;
         @(posedge clk);
         #1;
         if (stop_bytes > 0 && byte_q.size() >= stop_bytes) break;
         if (extra == 0) break;
         if (extra > 0) extra--;
      end
      start = 1'b0;
      ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b1; ready = 1'b1; sel = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (addr_a !== 5'd0)  begin errors++; $display("FAIL reset_addr_a got %0h want 0", addr_a); end
      checks++; if (data_a !== 8'd0)  begin errors++; $display("FAIL reset_data_a got %0h want 0", data_a); end
      checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL reset_valid_a got %0b want 0", valid_a); end
      checks++; if (busy_a !== 1'b0)  begin errors++; $display("FAIL reset_busy_a got %0b want 0", busy_a); end
      checks++; if (done_a !== 1'b0)  begin errors++; $display("FAIL reset_done_a got %0b want 0", done_a); end
      checks++; if (addr_b !== 3'd0)  begin errors++; $display("FAIL reset_addr_b got %0h want 0", addr_b); end
      checks++; if (data_b !== 8'd0)  begin errors++; $display("FAIL reset_data_b got %0h want 0", data_b); end
      checks++; if (valid_b !== 1'b0) begin errors++; $display("FAIL reset_valid_b got %0b want 0", valid_b); end
      checks++; if (busy_b !== 1'b0)  begin errors++; $display("FAIL reset_busy_b got %0b want 0", busy_b); end
      start = 1'b0; ready = 1'b0;
      #1 rst_n = 1'b1;
   endtask

   task automatic test_basic();
      int got;
      do_reset(); sel = 1'b0;
      run(400, 1, 0, 1'b0, 1'b0, -1);
      checks++; if (byte_q.size() != 128) begin errors++; $display("FAIL basic_count got %0d want 128", byte_q.size()); end
      for (int n = 0; n < byte_q.size() && n < 128; n++) begin
         checks++;
         if (byte_q[n] !== exp_a(n)) begin errors++; $display("FAIL basic_byte[%0d] got %0h want %0h", n, byte_q[n], exp_a(n)); end
      end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done_cnt got %0d want 1", done_cnt); end
      got = (done_cyc.size() > 0) ? done_cyc[0] : -1;
      checks++; if (got != 161) begin errors++; $display("FAIL basic_done_cycle got %0d want 161", got); end
      checks++; if (idle_after_done != 1) begin errors++; $display("FAIL basic_busy_drop got %0d want 1", idle_after_done); end
   endtask

   task automatic test_backpressure();
      do_reset(); sel = 1'b0;
      run(3000, 1, 0, 1'b1, 1'b0, -1);
      checks++; if (byte_q.size() != 128) begin errors++; $display("FAIL bp_count got %0d want 128", byte_q.size()); end
      for (int n = 0; n < byte_q.size() && n < 128; n++) begin
         checks++;
         if (byte_q[n] !== exp_a(n)) begin errors++; $display("FAIL bp_byte[%0d] got %0h want %0h", n, byte_q[n], exp_a(n)); end
      end
      checks++; if (stall_viol != 0) begin errors++; $display("FAIL bp_stable got %0d violations want 0", stall_viol); end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL bp_done_cnt got %0d want 1", done_cnt); end
   endtask

   task automatic test_start_while_busy();
      int got;
      do_reset(); sel = 1'b0;
      run(400, 1, 0, 1'b0, 1'b0, 10);
      checks++; if (byte_q.size() != 128) begin errors++; $display("FAIL swb_count got %0d want 128", byte_q.size()); end
      for (int n = 0; n < byte_q.size() && n < 128; n++) begin
         checks++;
         if (byte_q[n] !== exp_a(n)) begin errors++; $display("FAIL swb_byte[%0d] got %0h want %0h", n, byte_q[n], exp_a(n)); end
      end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL swb_done_cnt got %0d want 1", done_cnt); end
      got = (done_cyc.size() > 0) ? done_cyc[0] : -1;
      checks++; if (got != 161) begin errors++; $display("FAIL swb_done_cycle got %0d want 161", got); end
      checks++; if (restart_after_done != 0) begin errors++; $display("FAIL swb_restart got %0d want 0", restart_after_done); end
   endtask

   task automatic test_reset_mid_dump();
      int late_done;
      do_reset(); sel = 1'b0;
      run(400, 1, 22, 1'b0, 1'b0, -1);
      checks++; if (byte_q.size() != 22) begin errors++; $display("FAIL rmd_pre_count got %0d want 22", byte_q.size()); end
      checks++; if (addr_a !== 5'd5) begin errors++; $display("FAIL rmd_pre_addr got %0d want 5", addr_a); end
      checks++; if (valid_a !== 1'b1 || data_a !== 8'h00) begin errors++; $display("FAIL rmd_pre_byte got v=%0b d=%0h want v=1 d=00", valid_a, data_a); end
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if ({addr_a, data_a, valid_a, busy_a, done_a} !== '0) begin
         errors++;
         $display("FAIL rmd_outputs got a=%0h d=%0h v=%0b b=%0b dn=%0b want all 0", addr_a, data_a, valid_a, busy_a, done_a);
      end
      rst_n = 1'b1;
      late_done = 0;
      for (int c = 0; c < 10; c++) begin
         if (done_a) late_done++;
         @(posedge clk);
         #1;
      end
      checks++; if (late_done != 0) begin errors++; $display("FAIL rmd_no_done got %0d want 0", late_done); end
      run(400, 1, 0, 1'b0, 1'b0, -1);
      checks++; if (byte_q.size() != 128) begin errors++; $display("FAIL rmd_count got %0d want 128", byte_q.size()); end
      for (int n = 0; n < byte_q.size() && n < 128; n++) begin
         checks++;
         if (byte_q[n] !== exp_a(n)) begin errors++; $display("FAIL rmd_byte[%0d] got %0h want %0h", n, byte_q[n], exp_a(n)); end
      end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL rmd_done_cnt got %0d want 1", done_cnt); end
   endtask

   task automatic test_back_to_back();
      int got0, got1;
      do_reset(); sel = 1'b0;
      run(800, 2, 0, 1'b0, 1'b1, -1);
      checks++; if (byte_q.size() != 256) begin errors++; $display("FAIL b2b_count got %0d want 256", byte_q.size()); end
      for (int n = 0; n < byte_q.size() && n < 256; n++) begin
         checks++;
         if (byte_q[n] !== exp_a(n % 128)) begin errors++; $display("FAIL b2b_byte[%0d] got %0h want %0h", n, byte_q[n], exp_a(n % 128)); end
      end
      checks++; if (done_cnt != 2) begin errors++; $display("FAIL b2b_done_cnt got %0d want 2", done_cnt); end
      got0 = (done_cyc.size() > 0) ? done_cyc[0] : -1;
      got1 = (done_cyc.size() > 1) ? done_cyc[1] : -1;
      checks++; if (got0 != 161) begin errors++; $display("FAIL b2b_done0_cycle got %0d want 161", got0); end
      checks++; if (got1 != 323) begin errors++; $display("FAIL b2b_done1_cycle got %0d want 323", got1); end
      checks++; if (idle_after_done != 2) begin errors++; $display("FAIL b2b_idle_gap got %0d want 2", idle_after_done); end
   endtask

   task automatic test_param();
      int got;
      do_reset(); sel = 1'b1;
      run(200, 1, 0, 1'b0, 1'b0, -1);
      checks++; if (byte_q.size() != 16) begin errors++; $display("FAIL param_count got %0d want 16", byte_q.size()); end
      for (int n = 0; n < byte_q.size() && n < 16; n++) begin
         checks++;
         if (byte_q[n] !== exp_b(n)) begin errors++; $display("FAIL param_byte[%0d] got %0h want %0h", n, byte_q[n], exp_b(n)); end
      end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL param_done_cnt got %0d want 1", done_cnt); end
      got = (done_cyc.size() > 0) ? done_cyc[0] : -1;
      checks++; if (got != 25) begin errors++; $display("FAIL param_done_cycle got %0d want 25", got); end
      sel = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; ready = 1'b0; sel = 1'b0;
      for (int k = 0; k < 32; k++) regs_a[k] = 32'hA500_0000 + 32'(k);
      for (int k = 0; k < 8; k++)  regs_b[k] = 16'h1200 + 16'(k);
      test_reset();
      test_basic();
      test_backpressure();
      test_start_while_busy();
      test_reset_mid_dump();
      test_back_to_back();
      test_param();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
